// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the add/subtract responder:
//   state_t  - FSM state encoding (IDLE, CALC, RESP)
//   OP_ADD   - req_op value selecting a + b
//   OP_SUB   - req_op value selecting a - b
// ---------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// ---------------------------------------------------------------------------
// addsub_core
// Purely combinational add/subtract of two unsigned WIDTH-bit operands.
// Ports:
//   a, b    [WIDTH-1:0]  in   unsigned operands
//   op                   in   OP_ADD / OP_SUB
//   result  [WIDTH:0]    out  {carry, sum} for add, {borrow, diff} for sub
//   zero                 out  low WIDTH bits of result are all zero
// ---------------------------------------------------------------------------
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH:0]   result,
    output logic             zero
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    // Zero-extending by one bit makes the top bit the carry for add; for
    // subtract the top bit wraps to 1 exactly when a < b, i.e. the borrow.
    always_comb begin
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        if (op == OP_SUB) begin
            result = a_ext - b_ext;
        end else begin
            result = a_ext + b_ext;
        end
        zero = (result[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/addsub_responder.sv
// ---------------------------------------------------------------------------
// addsub_responder
// Accepts one add/subtract request at a time over a valid/ready handshake,
// computes the result one cycle later and holds it on a valid/ready response
// port until consumed. IDLE -> CALC -> RESP -> IDLE.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_a, req_b [WIDTH-1:0] unsigned operands
//   req_op                   OP_ADD (0) or OP_SUB (1)
//   rsp_valid / rsp_ready    response handshake (valid only in RESP)
//   rsp_data [WIDTH:0]       {carry|borrow, result mod 2^WIDTH}
//   rsp_zero                 low WIDTH bits of rsp_data are zero
//   rsp_count [7:0]          responses delivered, wrapping (only when
//                            ADDSUB_CNT_EN is defined)
// Build option: define ADDSUB_CNT_EN to add the response counter.
// ---------------------------------------------------------------------------
module addsub_responder
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic             rsp_zero
`ifdef ADDSUB_CNT_EN
    ,
    output logic [7:0]       rsp_count
`endif
);

    state_t state;
    state_t state_next;

    logic             load_op;
    logic             load_res;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             op_p0;
    logic [WIDTH:0]   result;
    logic             zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        load_op    = 1'b0;
        load_res   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_op    = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                load_res   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: operands captured on the request handshake
    always_ff @(posedge clk) begin
        if (load_op) begin
            a_p0  <= req_a;
            b_p0  <= req_b;
            op_p0 <= req_op;
        end
    end

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a_p0),
        .b      (b_p0),
        .op     (op_p0),
        .result (result),
        .zero   (zero)
    );

    // Stage p1: result register, held through RESP until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else if (load_res) begin
            rsp_data <= result;
            rsp_zero <= zero;
        end
    end

`ifdef ADDSUB_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_count <= 8'd0;
        end else if (rsp_valid && rsp_ready) begin
            rsp_count <= rsp_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_responder.sv
// ---------------------------------------------------------------------------
// tb_addsub_responder
// Scoreboard bench for addsub_responder at WIDTH=4. The stimulus process
// pushes the hand-computed expected {rsp_data, rsp_zero} for each request;
// the monitor compares every presented response against the queue head.
// ---------------------------------------------------------------------------
module tb_addsub_responder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_data;
    logic             rsp_zero;
`ifdef ADDSUB_CNT_EN
    logic [7:0]       rsp_count;
`endif

    int checks   = 0;
    int failures = 0;
    int tb_cnt   = 0;
    logic [5:0] exp_q[$];

    addsub_responder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero)
`ifdef ADDSUB_CNT_EN
        ,
        .rsp_count (rsp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares whenever a response is presented; pops on handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%0h expected=none", rsp_data);
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(exp_q[0][5:1]));
                check("rsp_zero", 32'(rsp_zero), 32'(exp_q[0][0]));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    tb_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, push its expectation, and return once rsp_valid is
    // up (checking the 2-cycle latency from the handshake cycle).
    task automatic do_req(input logic [3:0] a, input logic [3:0] b, input logic op,
                          input logic [4:0] ed, input logic ez);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        exp_q.push_back({ed, ez});
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd2);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_zero",  32'(rsp_zero),  32'd0);

        // Basic add, then response handshake returns to IDLE
        do_req(4'd3, 4'd5, 1'b0, 5'b01000, 1'b0);
        tick();
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);

        // Carry, borrow, equal-subtract, plain subtract
        do_req(4'd15, 4'd1, 1'b0, 5'b10000, 1'b1);
        do_req(4'd2,  4'd5, 1'b1, 5'b11101, 1'b0);
        do_req(4'd9,  4'd9, 1'b1, 5'b00000, 1'b1);
        do_req(4'd12, 4'd3, 1'b1, 5'b01001, 1'b0);
        do_req(4'd0,  4'd0, 1'b0, 5'b00000, 1'b1);

        // Backpressure: hold RESP for 3 cycles with a competing request
        tick();
        rsp_ready = 1'b0;
        do_req(4'd6, 4'd7, 1'b0, 5'b01101, 1'b0);
        req_a     = 4'd1;
        req_b     = 4'd1;
        req_op    = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_data",  32'(rsp_data),  32'b01101);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        check("bp_no_queued", 32'(rsp_valid), 32'd0);

        // Reset while in CALC abandons the request
        req_a     = 4'd4;
        req_b     = 4'd4;
        req_op    = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        tb_cnt = 0;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_data",  32'(rsp_data),  32'd0);
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        do_req(4'd10, 4'd7, 1'b1, 5'b00011, 1'b0);
        tick();

`ifdef ADDSUB_CNT_EN
        check("cnt_value", 32'(rsp_count), 32'(tb_cnt));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tb_cnt = 0;
        check("cnt_reset", 32'(rsp_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic [4:0] s;
            a = 4'(i);
            b = 4'(i >> 4);
            s = {1'b0, a} + {1'b0, b};
            do_req(a, b, 1'b0, s, (s[3:0] == 4'd0));
        end
        tick();
        check("cnt_wrap", 32'(rsp_count), 32'd0);
`endif

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
